// File: rtl/i2c_segment_target_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_segment_target_pkg
// Brief    : Register map, CTRL bit positions, reset values and FSM states
// Revision : 1.0
// ============================================================================
package i2c_segment_target_pkg;

    localparam logic [1:0] c_reg_seg   = 2'd0;
    localparam logic [1:0] c_reg_ctrl  = 2'd1;
    localparam logic [1:0] c_reg_blink = 2'd2;

    localparam int c_ctrl_enable   = 0;
    localparam int c_ctrl_invert   = 1;
    localparam int c_ctrl_blink_en = 2;

    localparam logic [7:0] c_seg_rst   = 8'h00;
    localparam logic [2:0] c_ctrl_rst  = 3'b001;
    localparam logic [7:0] c_blink_rst = 8'h00;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ADDR       = 4'd1,
        S_ADDR_ACK   = 4'd2,
        S_PTR        = 4'd3,
        S_PTR_ACK    = 4'd4,
        S_WDATA      = 4'd5,
        S_WDATA_ACK  = 4'd6,
        S_RDATA      = 4'd7,
        S_RD_ACKCHK  = 4'd8,
        S_WAIT_STOP  = 4'd9
    } state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
// Module   : i2c_bus_sync
// Brief    : SCL/SDA synchronizers with SCL edge and START/STOP pulses
// Revision : 1.0
// ============================================================================
module i2c_bus_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_hist;
    logic       r_sda_hist;
    logic [2:0] r_arm;
    logic       w_scl;
    logic       w_sda;
    logic       w_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
            r_arm      <= 3'b000;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_hist <= r_scl_sync[1];
            r_sda_hist <= r_sda_sync[1];
            r_arm      <= {r_arm[1:0], 1'b1};
        end
    end

    // Events stay masked until the whole pipeline holds real pin samples,
    // so leaving reset mid-transfer cannot fake a START.
    assign w_armed    = r_arm[2];
    assign w_scl      = r_scl_sync[1];
    assign w_sda      = r_sda_sync[1];
    assign o_sda      = w_sda;
    assign o_scl_rise = w_armed &  w_scl & ~r_scl_hist;
    assign o_scl_fall = w_armed & ~w_scl &  r_scl_hist;
    assign o_start    = w_armed &  w_scl &  r_scl_hist &  r_sda_hist & ~w_sda;
    assign o_stop     = w_armed &  w_scl &  r_scl_hist & ~r_sda_hist &  w_sda;

endmodule
`default_nettype wire

// File: rtl/i2c_segment_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_segment_target
// Brief    : I2C target with SEG/CTRL/BLINK registers driving a 7-segment byte
// Revision : 1.0
// ============================================================================
module i2c_segment_target
    import i2c_segment_target_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR       = 7'h42,
    parameter int         BLINK_PRESCALE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] seg_out,
    output logic       reg_wr
);

    localparam logic [BLINK_PRESCALE-1:0] c_pre_one = {{(BLINK_PRESCALE-1){1'b0}}, 1'b1};

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    logic w_tick;
    logic [7:0] w_byte;
    logic [7:0] w_rd_data;

    state_t              r_state;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic [1:0]          r_ptr;
    logic                r_rw;
    logic                r_load;
    logic [7:0]          r_seg;
    logic [2:0]          r_ctrl;
    logic [7:0]          r_blink;
    logic                r_sda_oe;
    logic                r_reg_wr;
    logic [7:0]          r_seg_out;
    logic [BLINK_PRESCALE-1:0] r_pre;
    logic [7:0]          r_tick_cnt;
    logic                r_phase;

    i2c_bus_sync u_bus_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_scl      (scl_in),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_byte = {r_shift[6:0], w_sda};
    assign w_tick = &r_pre;

    always_comb begin
        w_rd_data = 8'h00;
        case (r_ptr)
            c_reg_seg:   w_rd_data = r_seg;
            c_reg_ctrl:  w_rd_data = {5'b00000, r_ctrl};
            c_reg_blink: w_rd_data = r_blink;
            default:     w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_ptr      <= 2'd0;
            r_rw       <= 1'b0;
            r_load     <= 1'b0;
            r_seg      <= c_seg_rst;
            r_ctrl     <= c_ctrl_rst;
            r_blink    <= c_blink_rst;
            r_sda_oe   <= 1'b0;
            r_reg_wr   <= 1'b0;
            r_pre      <= '0;
            r_tick_cnt <= 8'd0;
            r_phase    <= 1'b0;
        end else begin
            r_reg_wr <= 1'b0;
            r_pre    <= r_pre + c_pre_one;
            if (w_tick && r_blink != 8'd0) begin
                if (r_tick_cnt + 8'd1 == r_blink) begin
                    r_tick_cnt <= 8'd0;
                    r_phase    <= ~r_phase;
                end else begin
                    r_tick_cnt <= r_tick_cnt + 8'd1;
                end
            end

            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= 3'd0;
                r_sda_oe  <= 1'b0;
                r_load    <= 1'b0;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_load   <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_byte;
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                if (r_state == S_ADDR) begin
                                    r_rw    <= w_byte[0];
                                    r_state <= (w_byte[7:1] == I2C_ADDR) ? S_ADDR_ACK : S_WAIT_STOP;
                                end else if (r_state == S_PTR) begin
                                    r_ptr   <= w_byte[1:0];
                                    r_state <= S_PTR_ACK;
                                end else begin
                                    case (r_ptr)
                                        c_reg_seg:  r_seg  <= w_byte;
                                        c_reg_ctrl: r_ctrl <= w_byte[2:0];
                                        c_reg_blink: begin
                                            r_blink    <= w_byte;
                                            r_tick_cnt <= 8'd0;
                                            r_phase    <= 1'b0;
                                        end
                                        default: ;
                                    endcase
                                    r_reg_wr <= (r_ptr != 2'd3);
                                    r_ptr    <= r_ptr + 2'd1;
                                    r_state  <= S_WDATA_ACK;
                                end
                            end
                        end
                    end
                    // First SCL fall drives ACK low, second releases it.
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_sda_oe) begin
                                r_sda_oe <= 1'b1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                if (r_state == S_ADDR_ACK && r_rw) begin
                                    r_state  <= S_RDATA;
                                    r_shift  <= w_rd_data;
                                    r_sda_oe <= ~w_rd_data[7];
                                    r_ptr    <= r_ptr + 2'd1;
                                end else if (r_state == S_ADDR_ACK) begin
                                    r_state <= S_PTR;
                                end else begin
                                    r_state <= S_WDATA;
                                end
                            end
                        end
                    end
                    S_RDATA: begin
                        if (w_scl_fall && r_load) begin
                            r_load   <= 1'b0;
                            r_shift  <= w_rd_data;
                            r_sda_oe <= ~w_rd_data[7];
                            r_ptr    <= r_ptr + 2'd1;
                        end else if (w_scl_fall && r_bit_cnt != 3'd0) begin
                            r_sda_oe <= ~r_shift[6];
                            r_shift  <= {r_shift[6:0], 1'b0};
                        end else if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) r_state <= S_RD_ACKCHK;
                        end
                    end
                    S_RD_ACKCHK: begin
                        if (w_scl_fall) begin
                            r_sda_oe <= 1'b0;
                        end else if (w_scl_rise) begin
                            r_bit_cnt <= 3'd0;
                            r_load    <= ~w_sda;
                            r_state   <= w_sda ? S_WAIT_STOP : S_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_out <= 8'h00;
        end else if (!r_ctrl[c_ctrl_enable]) begin
            r_seg_out <= 8'h00;
        end else begin
            r_seg_out <= (r_seg ^ {8{r_ctrl[c_ctrl_invert]}})
                       & {8{~(r_ctrl[c_ctrl_blink_en] && (r_blink != 8'd0) && r_phase)}};
        end
    end

    assign sda_oe  = r_sda_oe;
    assign reg_wr  = r_reg_wr;
    assign seg_out = r_seg_out;

endmodule
`default_nettype wire

// File: tb/tb_i2c_segment_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_segment_target
// Brief    : Self-checking bench: I2C master tasks plus register-map model
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_segment_target;

    localparam logic [6:0] c_addr = 7'h42;
    localparam int         c_pre  = 2;
    localparam int         c_qt   = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic       sda_line;
    logic       sda_oe;
    logic       reg_wr;
    logic [7:0] seg_out;

    int n_vec = 0;
    int n_err = 0;
    int oe_cnt = 0;
    int wr_cnt = 0;

    logic [7:0] m_regs [4];
    logic [1:0] m_ptr;
    logic [7:0] wq [$];

    assign sda_line = ~(m_sda_low | sda_oe);

    i2c_segment_target #(
        .I2C_ADDR       (c_addr),
        .BLINK_PRESCALE (c_pre)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl_in  (m_scl),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .seg_out (seg_out),
        .reg_wr  (reg_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sda_oe) oe_cnt++;
        if (reg_wr) wr_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Reference model of the register map
    function automatic void model_reset();
        m_regs[0] = 8'h00; m_regs[1] = 8'h01; m_regs[2] = 8'h00; m_regs[3] = 8'h00;
        m_ptr = 2'd0;
    endfunction

    function automatic void model_write(input logic [7:0] d);
        if (m_ptr == 2'd1)      m_regs[1] = {5'b0, d[2:0]};
        else if (m_ptr != 2'd3) m_regs[m_ptr] = d;
        m_ptr = m_ptr + 2'd1;
    endfunction

    function automatic logic [7:0] model_read();
        logic [7:0] d;
        d = m_regs[m_ptr];
        m_ptr = m_ptr + 2'd1;
        return d;
    endfunction

    function automatic logic blink_active();
        return m_regs[1][2] && (m_regs[2] != 8'h00);
    endfunction

    function automatic logic [7:0] exp_seg();
        if (!m_regs[1][0]) return 8'h00;
        return m_regs[1][1] ? ~m_regs[0] : m_regs[0];
    endfunction

    // I2C master primitives
    task automatic bus_start();
        m_sda_low = 1'b0; #c_qt; m_scl = 1'b1; #c_qt; m_sda_low = 1'b1; #c_qt; m_scl = 1'b0; #c_qt;
    endtask

    task automatic bus_stop();
        m_sda_low = 1'b1; #c_qt; m_scl = 1'b1; #c_qt; m_sda_low = 1'b0; #c_qt;
    endtask

    task automatic put_bit(input logic b);
        m_sda_low = ~b; #c_qt; m_scl = 1'b1; #(2*c_qt); m_scl = 1'b0; #c_qt;
    endtask

    task automatic get_bit(output logic b);
        m_sda_low = 1'b0; #c_qt; m_scl = 1'b1; #c_qt; b = sda_line; #c_qt; m_scl = 1'b0; #c_qt;
    endtask

    task automatic put_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i]);
        get_bit(b);
        ack = ~b;
    endtask

    task automatic get_byte(output logic [7:0] d, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(~ack);
    endtask

    task automatic set_ptr(input logic [7:0] p);
        logic ack;
        bus_start();
        put_byte({c_addr, 1'b0}, ack);
        check_eq("ack_addr_w", ack, 1'b1);
        put_byte(p, ack);
        check_eq("ack_ptr", ack, 1'b1);
        m_ptr = p[1:0];
    endtask

    task automatic wr_txn(input logic [7:0] p);
        logic ack;
        set_ptr(p);
        foreach (wq[i]) begin
            put_byte(wq[i], ack);
            check_eq("ack_data", ack, 1'b1);
            model_write(wq[i]);
        end
        bus_stop();
        repeat (4) @(negedge clk);
    endtask

    task automatic rd_txn(input int n);
        logic       ack;
        logic [7:0] d;
        bus_start();
        put_byte({c_addr, 1'b1}, ack);
        check_eq("ack_addr_r", ack, 1'b1);
        for (int i = 0; i < n; i++) begin
            get_byte(d, i < n - 1);
            check_eq("rd_data", d, model_read());
        end
        check_eq("rd_release", sda_oe, 1'b0);
        bus_stop();
        repeat (4) @(negedge clk);
    endtask

    int         base;
    int         run;
    int         nruns;
    int         bad;
    logic       seen;
    logic [7:0] prev;
    logic       ack_v;
    logic       bit_v;
    int         op;
    int         nb;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_sda_oe", sda_oe, 1'b0);
        check_eq("rst_seg_out", seg_out, 8'h00);
        check_eq("rst_reg_wr", reg_wr, 1'b0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Basic write
        base = wr_cnt;
        wq = '{8'h3F};
        wr_txn(8'h00);
        check_eq("t1_seg_out", seg_out, 8'h3F);
        check_eq("t1_reg_wr_pulses", wr_cnt - base, 1);

        // Foreign address never driven
        base = oe_cnt;
        bus_start();
        put_byte({7'h43, 1'b0}, ack_v);
        check_eq("t2_nack_addr", ack_v, 1'b0);
        put_byte(8'h00, ack_v);
        put_byte(8'hFF, ack_v);
        bus_stop();
        repeat (4) @(negedge clk);
        check_eq("t2_no_drive", oe_cnt - base, 0);
        check_eq("t2_seg_out", seg_out, exp_seg());

        // Burst write with wrap, invert and blink
        wq = '{8'h05, 8'h00, 8'hAA, 8'h07};
        wr_txn(8'h02);
        prev = seg_out; run = 0; nruns = 0; bad = 0; seen = 1'b0;
        repeat (170) begin
            @(negedge clk);
            if (seg_out != exp_seg() && seg_out != 8'h00) bad++;
            if (seg_out != prev) begin
                if (seen) begin
                    check_eq("t3_blink_run", run, m_regs[2] * (1 << c_pre));
                    nruns++;
                end
                seen = 1'b1; run = 1; prev = seg_out;
            end else begin
                run++;
            end
        end
        check_eq("t3_blink_values", bad, 0);
        check_eq("t3_blink_runs", nruns >= 3, 1'b1);

        // Pointer write, repeated START, two-byte read
        set_ptr(8'h00);
        rd_txn(2);

        // Aborted write byte
        base = wr_cnt;
        set_ptr(8'h01);
        put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
        bus_stop();
        repeat (4) @(negedge clk);
        check_eq("t5_no_reg_wr", wr_cnt - base, 0);
        set_ptr(8'h00);
        rd_txn(3);

        // Randomized traffic against the model
        for (int it = 0; it < 24; it++) begin
            op = $urandom_range(0, 2);
            nb = $urandom_range(1, 4);
            if (op == 0) begin
                wq = {};
                for (int k = 0; k < nb; k++) wq.push_back(8'($urandom));
                wr_txn(8'($urandom));
                if (!blink_active()) check_eq("rnd_seg_out", seg_out, exp_seg());
            end else if (op == 1) begin
                set_ptr(8'($urandom));
                rd_txn(nb);
            end else begin
                rd_txn(nb);
            end
        end

        // Reset in the middle of a read while SDA is driven
        wq = '{8'h0F};
        wr_txn(8'h00);
        set_ptr(8'h00);
        bus_start();
        put_byte({c_addr, 1'b1}, ack_v);
        check_eq("t6_ack_addr_r", ack_v, 1'b1);
        check_eq("t6_rd_drive", sda_oe, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_sda_oe", sda_oe, 1'b0);
        check_eq("t6_rst_seg_out", seg_out, 8'h00);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = oe_cnt;
        for (int k = 0; k < 9; k++) get_bit(bit_v);
        bus_stop();
        repeat (4) @(negedge clk);
        check_eq("t6_bus_ignored", oe_cnt - base, 0);
        check_eq("t6_seg_after_rst", seg_out, exp_seg());
        wq = '{8'h5A};
        wr_txn(8'h00);
        check_eq("t6_seg_out", seg_out, 8'h5A);
        set_ptr(8'h00);
        rd_txn(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
